e_mdu: RTL and testbench

- E-stage multiply/divide unit with architectural HI/LO registers.
- Sits in parallel with the E-stage ALU and is driven by the same forwarded rs/rt operands.
- Services mult/multu/div/divu/mthi/mtlo and exposes HI/LO to the E-stage result mux for mfhi/mflo.
- Reports busy so the stall unit can hold any HI/LO-touching instruction in D.

---
 rtl/e_mdu_pkg.sv | 47 ++++
 rtl/e_mdu_if.sv | 21 ++
 rtl/e_mdu_calc.sv | 57 +++++
 rtl/e_mdu.sv | 94 +++++++++
 tb/tb_e_mdu.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/e_mdu_pkg.sv
// -----------------------------------------------------------------------------
// e_mdu_pkg: shared definitions for the E-stage multiply/divide unit.
//   - mdu_op_e   : MDUOp encodings driven by the control unit.
//   - *_DEF      : default busy latencies (cycles after the issue edge).
//   - WDSEL_HI/LO: write-data select codes for mfhi/mflo, extending the
//                  existing WDSel set (ALU=0, MEM=1, PC8=2).
//   - is_long_op / is_div_op: operation classification helpers.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu become long ops).
// -----------------------------------------------------------------------------
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [2:0] WDSEL_HI = 3'd3;
  localparam logic [2:0] WDSEL_LO = 3'd4;

  // Long ops occupy the unit for several cycles and raise start/busy.
  function automatic logic is_long_op(input logic [3:0] op);
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: is_long_op = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: is_long_op = 1'b1;
`endif
      default: is_long_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    is_div_op = (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// -----------------------------------------------------------------------------
// e_mdu_if: E-stage <-> MDU bundle.
//   MDUOp (4) : operation, MDU_NONE when idle          (master -> slave)
//   A, B (32) : forwarded rs / rt operands             (master -> slave)
//   start     : combinational long-op request, to stall (slave -> master)
//   busy      : registered, long op in flight          (slave -> master)
//   HI, LO    : committed architectural HI/LO          (slave -> master)
// Optional feature macro: MDU_MADD_EN (no effect on this bundle).
// -----------------------------------------------------------------------------
interface e_mdu_if;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output MDUOp, A, B, input start, busy, HI, LO);
  modport slave  (input MDUOp, A, B, output start, busy, HI, LO);
endinterface

// File: rtl/e_mdu_calc.sv
// -----------------------------------------------------------------------------
// e_mdu_calc: combinational result generator for the MDU.
//   op (4)      : MDUOp
//   a, b (32)   : operands (rs, rt)
//   hi, lo (32) : currently committed HI/LO
//   res (64)    : {HI_tmp, LO_tmp} to latch at the issue edge
// Division by zero returns {hi, lo} so the commit leaves HI/LO unchanged.
// INT_MIN / -1 is pinned to quotient INT_MIN, remainder 0.
// Optional feature macro: MDU_MADD_EN adds {hi,lo} +/- product.
// -----------------------------------------------------------------------------
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic        div_ovf;

  // Sign/zero extension to 64 bits makes the low 64 bits of the product exact.
  assign prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u  = {32'd0, a} * {32'd0, b};
  assign b_zero  = (b == 32'd0);
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    res = {hi, lo};
    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV: begin
        if (div_ovf)      res = {32'd0, 32'h8000_0000};
        else if (!b_zero) res = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
      end
      MDU_DIVU: begin
        if (!b_zero) res = {a % b, a / b};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  res = {hi, lo} + prod_s;
      MDU_MADDU: res = {hi, lo} + prod_u;
      MDU_MSUB:  res = {hi, lo} - prod_s;
      MDU_MSUBU: res = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu: E-stage multiply/divide unit with architectural HI/LO.
//   clk   : pipeline clock
//   reset : synchronous, active-high; clears all state, aborts an operation
//   bus   : e_mdu_if.slave (MDUOp, A, B in; start, busy, HI, LO out)
// A long op is computed at its issue edge into HI_tmp/LO_tmp; busy then stays
// high for MULT_CYCLES or DIV_CYCLES cycles and HI/LO commit on the edge where
// busy falls. mthi/mtlo write directly in IDLE. Ops presented while BUSY are
// ignored.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu, MULT_CYCLES).
// -----------------------------------------------------------------------------
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state;
  logic               busy;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        hi_tmp;
  logic [31:0]        lo_tmp;
  logic [63:0]        calc_res;
  logic               start;

  assign start = is_long_op(bus.MDUOp);

  e_mdu_calc u_calc (
    .op  (bus.MDUOp),
    .a   (bus.A),
    .b   (bus.B),
    .hi  (hi),
    .lo  (lo),
    .res (calc_res)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            {hi_tmp, lo_tmp} <= calc_res;
            cnt   <= is_div_op(bus.MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state <= S_BUSY;
            busy  <= 1'b1;
          end else if (bus.MDUOp == MDU_MTHI) begin
            hi <= bus.A;
          end else if (bus.MDUOp == MDU_MTLO) begin
            lo <= bus.A;
          end
        end
        S_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          // Last busy cycle: commit so the new value appears as busy falls.
          if (cnt == CNT_W'(1)) begin
            hi    <= hi_tmp;
            lo    <= lo_tmp;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.start = start;
  assign bus.busy  = busy;
  assign bus.HI    = hi;
  assign bus.LO    = lo;

endmodule

// File: tb/tb_e_mdu.sv
// -----------------------------------------------------------------------------
// tb_e_mdu: self-checking bench for e_mdu. Stimulus pushes the expected
// {HI, LO} of every long op into a queue; a monitor pops and compares when
// busy falls. Busy length, held values, mthi/mtlo and reset abort are checked
// inline by the stimulus.
// Optional feature macro: MDU_MADD_EN selects the madd test or the
// "encoding is ignored" test.
// -----------------------------------------------------------------------------
module tb_e_mdu;
  import e_mdu_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic   clk;
  logic   reset;
  int     checks;
  int     errors;
  exp_t   sb[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a falling busy outside reset is a commit; compare with the queue.
  initial begin
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !bus.busy) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got HI=%h LO=%h expected no commit", bus.HI, bus.LO);
          end else begin
            e = sb.pop_front();
            check({e.name, " HI"}, {32'd0, bus.HI}, {32'd0, e.hi});
            check({e.name, " LO"}, {32'd0, bus.LO}, {32'd0, e.lo});
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  // Issue a long op, count busy cycles, optionally present MTLO/MULT mid-flight.
  task automatic run_op(input string name, input mdu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] ehi,
                        input logic [31:0] elo, input bit interfere);
    exp_t e;
    int   cnt;
    @(negedge clk);
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    #1 check({name, " start"}, {63'd0, bus.start}, 64'd1);
    e.name = name;
    e.hi   = ehi;
    e.lo   = elo;
    sb.push_back(e);
    @(negedge clk);
    bus.MDUOp = MDU_NONE;
    bus.A     = '0;
    bus.B     = '0;
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      cnt++;
      if (cnt == 1) check({name, " held"}, {bus.HI, bus.LO}, {m_hi, m_lo});
      if (interfere && cnt == 4) check({name, " lo_ignored"}, {32'd0, bus.LO}, {32'd0, m_lo});
      if (interfere && cnt == 2) begin
        bus.MDUOp = MDU_MTLO;
        bus.A     = 32'hDEAD_BEEF;
      end else if (interfere && cnt == 3) begin
        bus.MDUOp = MDU_MULT;
        bus.A     = 32'd3;
        bus.B     = 32'd3;
      end else begin
        bus.MDUOp = MDU_NONE;
        bus.A     = '0;
        bus.B     = '0;
      end
      @(negedge clk);
    end
    bus.MDUOp = MDU_NONE;
    check({name, " busy_cycles"}, 64'(cnt), 64'(n));
    m_hi = ehi;
    m_lo = elo;
  endtask

  task automatic mt(input string name, input mdu_op_e op, input logic [31:0] val);
    @(negedge clk);
    bus.MDUOp = op;
    bus.A     = val;
    #1 check({name, " start"}, {63'd0, bus.start}, 64'd0);
    @(negedge clk);
    bus.MDUOp = MDU_NONE;
    bus.A     = '0;
    if (op == MDU_MTHI) m_hi = val;
    else                m_lo = val;
    check({name, " busy"}, {63'd0, bus.busy}, 64'd0);
    check({name, " HILO"}, {bus.HI, bus.LO}, {m_hi, m_lo});
  endtask

  initial begin
    bit saw_busy;
    checks    = 0;
    errors    = 0;
    m_hi      = '0;
    m_lo      = '0;
    bus.MDUOp = MDU_NONE;
    bus.A     = '0;
    bus.B     = '0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset HILO", {bus.HI, bus.LO}, 64'd0);
    check("reset start", {63'd0, bus.start}, 64'd0);

    run_op("mult_m3x5",   MDU_MULT,  32'hFFFF_FFFD, 32'd5,         5,  32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("divu_7_2",    MDU_DIVU,  32'd7,         32'd2,         10, 32'd1,         32'd3,         1'b0);
    run_op("div_m7_2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_7_m2",    MDU_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD, 1'b0);
    run_op("divu_big",    MDU_DIVU,  32'hFFFF_FFFF, 32'h10,        10, 32'hF,         32'h0FFF_FFFF, 1'b0);
    run_op("div_intmin",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000, 1'b0);
    mt("mthi", MDU_MTHI, 32'h1234_5678);
    run_op("div_by_zero", MDU_DIV,   32'd5,         32'd0,         10, 32'h1234_5678, 32'h8000_0000, 1'b0);
    run_op("multu_ones",  MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_ones",   MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'd0,         32'd1,         1'b0);

    // multu aborted by reset on its third busy cycle: no commit may follow.
    @(negedge clk);
    bus.MDUOp = MDU_MULTU;
    bus.A     = 32'd1000;
    bus.B     = 32'd1000;
    @(negedge clk);
    bus.MDUOp = MDU_NONE;
    check("abort busy1", {63'd0, bus.busy}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    check("abort busy", {63'd0, bus.busy}, 64'd0);
    check("abort HILO", {bus.HI, bus.LO}, 64'd0);
    saw_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy) saw_busy = 1'b1;
    end
    check("abort no_busy", {63'd0, saw_busy}, 64'd0);
    check("abort no_commit", {bus.HI, bus.LO}, 64'd0);

    run_op("mult_interf", MDU_MULT,  32'd7,         32'd6,         5,  32'd0,         32'd42,        1'b1);

`ifdef MDU_MADD_EN
    mt("madd_mthi", MDU_MTHI, 32'd0);
    mt("madd_mtlo", MDU_MTLO, 32'hFFFF_FFFF);
    run_op("maddu_1_1",   MDU_MADDU, 32'd1,         32'd1,         5,  32'd1,         32'd0,         1'b0);
`else
    @(negedge clk);
    bus.MDUOp = MDU_MADDU;
    bus.A     = 32'd1;
    bus.B     = 32'd1;
    #1 check("maddu_off start", {63'd0, bus.start}, 64'd0);
    @(negedge clk);
    bus.MDUOp = MDU_NONE;
    check("maddu_off busy", {63'd0, bus.busy}, 64'd0);
    check("maddu_off HILO", {bus.HI, bus.LO}, {m_hi, m_lo});
`endif

    repeat (3) @(negedge clk);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
